// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - state encoding and ALU opcode constants shared by the operand sequencer
package alu_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    // Opcode values understood by the ALU downstream
    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_SRL = 3'd7;

endpackage

// File: rtl/button_edge_sync.sv
// rtl/button_edge_sync.sv - two-flop synchronizer with a rising-edge one-shot for a raw button
module button_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pulse
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign pulse = s2 & ~s3;

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - loads ALU operands/opcode per button press and captures the result
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic         btn_next,
    input  logic         btn_clear,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] op_a,
    output logic [N-1:0] op_b,
    output logic [2:0]   op_uc,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic [2:0]   state_o,
    output logic         done
);

    state_t state;
    state_t state_next;
    logic   next_p;
    logic   next_level;
    logic   clear_level;
    logic   clear_pulse;
    logic   load_a;
    logic   load_b;
    logic   load_op;
    logic   capture;
    logic   zero_all;

    button_edge_sync u_next_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_next),
        .level (next_level),
        .pulse (next_p)
    );

    button_edge_sync u_clear_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .level (clear_level),
        .pulse (clear_pulse)
    );

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        capture    = 1'b0;
        zero_all   = 1'b0;
        if (clear_level) begin
            state_next = LOAD_A;
            zero_all   = 1'b1;
        end else begin
            case (state)
                LOAD_A:  if (next_p) begin load_a  = 1'b1; state_next = LOAD_B;  end
                LOAD_B:  if (next_p) begin load_b  = 1'b1; state_next = LOAD_OP; end
                LOAD_OP: if (next_p) begin load_op = 1'b1; state_next = EXEC;    end
                // EXEC ignores next_p: the ALU gets one full stable cycle
                EXEC: begin
                    capture    = 1'b1;
                    state_next = SHOW;
                end
                SHOW:    if (next_p) state_next = LOAD_A;
                default: begin
                    state_next = LOAD_A;
                    zero_all   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LOAD_A;
            done     <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            op_uc    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state <= state_next;
            done  <= (state_next == SHOW);
            if (zero_all) begin
                op_a     <= '0;
                op_b     <= '0;
                op_uc    <= '0;
                result_q <= '0;
                flags_q  <= '0;
            end else begin
                if (load_a)  op_a  <= sw;
                if (load_b)  op_b  <= sw;
                if (load_op) op_uc <= sw[2:0];
                if (capture) begin
                    result_q <= alu_result;
                    flags_q  <= alu_flags;
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Upstream control stage for the N-bit ALU on the lab board. It takes operand A, operand B and the 3-bit opcode (UC) from the switches, one value per debounced button press, and drives them into the ALU. After the ALU output settles, it captures RESULT and FLAGS into registers that feed the display logic. Everything is owned by a single state machine, so ALU inputs change only at defined points.

Parameters:
N, 4, operand/result width; must equal the ALU's N; N >= 3 because the opcode is read from the switch bits [2:0].

Ports:
clk  input  1  system clock
rst_n  input  1  reset; synchronous, active-low
sw  input  N  switch bank; raw, quasi-static
btn_next  input  1  raw push button; each press advances the sequence
btn_clear  input  1  raw push button; returns to LOAD_A and zeroes all registers
alu_result  input  N  RESULT from the ALU
alu_flags  input  4  FLAGS from the ALU
op_a  output  N  ALU operand A, registered
op_b  output  N  ALU operand B, registered
op_uc  output  3  ALU opcode, registered
result_q  output  N  captured ALU result
flags_q  output  4  captured ALU flags
state_o  output  3  current state encoding, for the LEDs
done  output  1  high while in SHOW

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = LOAD_A.
  - op_a, op_b, op_uc, result_q, flags_q = 0.
  - done = 0.
  - All synchronizer flops = 0.
  - Reset has priority over every other input, including mid-sequence and during EXEC.
- Button conditioning:
  - btn_next passes through two synchronizer flops (s1, s2), then an edge flop (s3).
  - next_p = s2 & ~s3.
  - If btn_next is first sampled high at edge k, next_p is high for exactly one cycle and the state updates at edge k+2.
  - Holding the button produces one pulse only.
- btn_clear: two-flop synchronized, level-sensitive. While the synchronized level is 1:
  - state forced to LOAD_A;
  - all data registers zeroed;
  - clear beats next_p on the same cycle.
- States (encoding in the package): LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4.
  - LOAD_A: on next_p, op_a <= sw, go to LOAD_B.
  - LOAD_B: on next_p, op_b <= sw, go to LOAD_OP.
  - LOAD_OP: on next_p, op_uc <= sw[2:0], go to EXEC.
  - EXEC: exactly one cycle; no condition.
    - Gives the combinational ALU one full cycle with stable inputs.
    - At the end of the cycle: result_q <= alu_result, flags_q <= alu_flags, go to SHOW.
    - A next_p arriving during EXEC is dropped.
  - SHOW: done = 1.
    - On next_p, go to LOAD_A.
    - op_a, op_b, op_uc and result_q keep their values until overwritten.
- Opcode 0 (ALU default case) is legal and passes through unchanged. The captured result and flags are whatever the ALU returns.
- Outside the capture edge, result_q and flags_q do not follow alu_result.
- op_* change only on their load edge or on clear/reset, so the ALU inputs never glitch between loads.
- done is registered and derived from the next state: it rises on the edge that enters SHOW.
- Unused state encodings (5-7) go to LOAD_A on the next edge with all registers zeroed.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum (3-bit);
  - opcode constants: OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_SLL=6, OP_SRL=7. These are shared with the ALU.
- Sub-module button_edge_sync contains the 2-flop synchronizer plus the rising-edge one-shot. It has its own rst_n and outputs both the level and the pulse. One instance each for btn_next and btn_clear (the clear instance uses the level output).

Test Plan:
All scenarios use N=4 with the real ALU instantiated.
- Reset: hold rst_n=0 for 3 cycles with sw=4'hF and both buttons high -> after release, state_o=0, all outputs 0, done=0.
- Full add:
  - Stimulus: press next with sw=0011, then 0101, then 001.
  - Required: op_a=0011, op_b=0101, op_uc=1; EXEC lasts 1 cycle; result_q=1000; done=1.
  - Timing: each state change lands at the edge k+2 after the first sampled press.
- Held button: hold btn_next high for 20 cycles in LOAD_A with sw=1010 -> exactly one transition to LOAD_B, op_a=1010.
- Clear mid-sequence: in LOAD_OP, assert btn_clear together with btn_next -> state LOAD_A, all registers 0; the next press is not honoured.
- Press during EXEC and repeat cycle:
  - Stimulus: time a press so next_p lands in EXEC, op 2, A=0111, B=0010.
  - Required: stays in SHOW with result_q=0101; the next press goes to LOAD_A with op_a still 0111.
- Opcode 0 and reset during SHOW:
  - Opcode 0 -> result_q=0000, flags_q=0000.
  - Then rst_n=0 for 1 cycle in SHOW -> all outputs 0, state_o=0.
